// File: rtl/mem_port_arbiter_if.sv
// Requester, bus and error signals between the memory port arbiter and its environment.
// Latency: none, wiring only.
// Backpressure: requests are held by their owners until the matching ready pulse.
interface mem_port_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    // instruction fetch side
    logic                  if_req;
    logic [ADDR_WIDTH-1:0] if_addr;
    logic [DATA_WIDTH-1:0] if_rdata;
    logic                  if_ready;
    // data access side
    logic                  dm_rd_en;
    logic                  dm_wr_en;
    logic [ADDR_WIDTH-1:0] dm_addr;
    logic [DATA_WIDTH-1:0] dm_wdata;
    logic [DATA_WIDTH-1:0] dm_rdata;
    logic                  dm_ready;
    logic                  stall;
    // external memory bus
    logic                  bus_req;
    logic                  bus_we;
    logic [ADDR_WIDTH-1:0] bus_addr;
    logic [DATA_WIDTH-1:0] bus_wdata;
    logic [DATA_WIDTH-1:0] bus_rdata;
    logic                  bus_ack;
    // error reporting
    logic                  err_clr;
    logic                  bus_error;

    // arbiter side: it masters the external bus
    modport master (
        input  if_req, if_addr, dm_rd_en, dm_wr_en, dm_addr, dm_wdata,
               bus_rdata, bus_ack, err_clr,
        output if_rdata, if_ready, dm_rdata, dm_ready, stall,
               bus_req, bus_we, bus_addr, bus_wdata, bus_error
    );

    // environment side: requesters and memory
    modport slave (
        output if_req, if_addr, dm_rd_en, dm_wr_en, dm_addr, dm_wdata,
               bus_rdata, bus_ack, err_clr,
        input  if_rdata, if_ready, dm_rdata, dm_ready, stall,
               bus_req, bus_we, bus_addr, bus_wdata, bus_error
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and data accesses, with starvation bound and timeout abort.
// Latency: grant edge after request, bus_req next cycle, ready combinational in the ack cycle (min 2 cycles).
// Backpressure: requesters hold until ready; data requests raise stall until dm_ready.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int MAX_WAIT     = 16,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    mem_port_arbiter_if.master  p
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] IF_ACC = 2'd1;
    localparam logic [1:0] DM_ACC = 2'd2;

    localparam int WW = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(MAX_WAIT - 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    logic [1:0]    state;
    logic [WW-1:0] wait_cnt;
    logic [SW-1:0] starve_cnt;

    logic dm_req;
    logic dm_grant;
    logic if_grant;
    logic in_acc;
    logic timeout;
    logic done;

    assign dm_req   = p.dm_rd_en | p.dm_wr_en;
    // DM is preferred until fetch has lost STARVE_LIMIT times in a row
    assign dm_grant = (state == IDLE) & dm_req & (~p.if_req | (starve_cnt < STARVE_MAX));
    assign if_grant = (state == IDLE) & p.if_req & ~dm_grant;
    assign in_acc   = (state != IDLE);
    assign timeout  = in_acc & ~p.bus_ack & (wait_cnt == WAIT_LAST);
    assign done     = in_acc & (p.bus_ack | timeout);

    // ready and data go only to the owner of the current bus cycle; aborted cycles return zero
    assign p.if_ready = (state == IF_ACC) & done;
    assign p.dm_ready = (state == DM_ACC) & done;
    assign p.if_rdata = ((state == IF_ACC) && p.bus_ack) ? p.bus_rdata : '0;
    assign p.dm_rdata = ((state == DM_ACC) && p.bus_ack) ? p.bus_rdata : '0;
    assign p.stall    = dm_req & ~p.dm_ready;

    // arbitration, grant latching and bus cycle tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            p.bus_req   <= 1'b0;
            p.bus_we    <= 1'b0;
            p.bus_addr  <= '0;
            p.bus_wdata <= '0;
            wait_cnt    <= '0;
            starve_cnt  <= '0;
        end else if (state == IDLE) begin
            wait_cnt <= '0;
            if (dm_grant) begin
                state       <= DM_ACC;
                p.bus_req   <= 1'b1;
                p.bus_we    <= p.dm_wr_en;
                p.bus_addr  <= p.dm_addr;
                p.bus_wdata <= p.dm_wdata;
                if (p.if_req) begin
                    starve_cnt <= starve_cnt + 1'b1;
                end
            end else if (if_grant) begin
                state       <= IF_ACC;
                p.bus_req   <= 1'b1;
                p.bus_we    <= 1'b0;
                p.bus_addr  <= p.if_addr;
                p.bus_wdata <= '0;
                starve_cnt  <= '0;
            end
        end else if (done) begin
            state     <= IDLE;
            p.bus_req <= 1'b0;
            p.bus_we  <= 1'b0;
            wait_cnt  <= '0;
        end else begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // sticky timeout flag; a new timeout beats a simultaneous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p.bus_error <= 1'b0;
        end else if (timeout) begin
            p.bus_error <= 1'b1;
        end else if (p.err_clr) begin
            p.bus_error <= 1'b0;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
// Latency: n/a.
// Backpressure: bench requesters hold requests until the ready pulse they observe.
module tb_mem_port_arbiter;
    localparam int MAX_WAIT     = 16;
    localparam int STARVE_LIMIT = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    mem_port_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus_if ();

    mem_port_arbiter #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_WAIT(MAX_WAIT), .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .p(bus_if)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // transaction-level model: who owns the bus, what was latched, how long it has waited
    int          m_owner = 0;       // 0 none, 1 fetch, 2 data
    logic [31:0] m_addr, m_wdata;
    logic        m_we;
    int          m_wait = 0;
    int          m_losses = 0;      // consecutive DM wins while fetch was waiting
    logic        m_err = 1'b0;
    logic        if_seen = 1'b0;
    logic        dm_seen = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_owner = 0; m_wait = 0; m_losses = 0; m_err = 1'b0;
                if_seen = 1'b0; dm_seen = 1'b0;
                chk("rst_bus_req", 32'(bus_if.bus_req), 32'd0);
            end else begin
                logic dm_req, ack, to, e_ifr, e_dmr;
                dm_req = bus_if.dm_rd_en | bus_if.dm_wr_en;
                ack    = (m_owner != 0) && bus_if.bus_ack;
                to     = (m_owner != 0) && !bus_if.bus_ack && (m_wait == MAX_WAIT - 1);
                e_ifr  = (m_owner == 1) && (ack || to);
                e_dmr  = (m_owner == 2) && (ack || to);
                chk("m_bus_req", 32'(bus_if.bus_req), 32'(m_owner != 0));
                if (m_owner != 0) begin
                    chk("m_bus_addr", bus_if.bus_addr, m_addr);
                    chk("m_bus_we", 32'(bus_if.bus_we), 32'(m_we));
                    if (m_we) chk("m_bus_wdata", bus_if.bus_wdata, m_wdata);
                end
                chk("m_if_ready", 32'(bus_if.if_ready), 32'(e_ifr));
                chk("m_dm_ready", 32'(bus_if.dm_ready), 32'(e_dmr));
                if (m_owner != 1) chk("m_if_rdata_idle", bus_if.if_rdata, 32'd0);
                if (m_owner != 2) chk("m_dm_rdata_idle", bus_if.dm_rdata, 32'd0);
                if (e_ifr) chk("m_if_rdata", bus_if.if_rdata, ack ? bus_if.bus_rdata : 32'd0);
                if (e_dmr && !m_we) chk("m_dm_rdata", bus_if.dm_rdata, ack ? bus_if.bus_rdata : 32'd0);
                if (e_dmr && to) chk("m_dm_rdata_to", bus_if.dm_rdata, 32'd0);
                chk("m_stall", 32'(bus_if.stall), 32'(dm_req && !e_dmr));
                chk("m_bus_error", 32'(bus_if.bus_error), 32'(m_err));
                if_seen = bus_if.if_ready;
                dm_seen = bus_if.dm_ready;
                // advance to the state after the coming edge
                if (to) m_err = 1'b1;
                else if (bus_if.err_clr) m_err = 1'b0;
                if (m_owner != 0) begin
                    if (ack || to) begin m_owner = 0; m_wait = 0; end
                    else m_wait++;
                end else if (dm_req && (!bus_if.if_req || m_losses < STARVE_LIMIT)) begin
                    m_owner = 2; m_addr = bus_if.dm_addr; m_wdata = bus_if.dm_wdata;
                    m_we = bus_if.dm_wr_en; m_wait = 0;
                    if (bus_if.if_req) m_losses++;
                end else if (bus_if.if_req) begin
                    m_owner = 1; m_addr = bus_if.if_addr; m_we = 1'b0; m_wait = 0; m_losses = 0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus_if.if_req = 0; bus_if.if_addr = 0; bus_if.dm_rd_en = 0; bus_if.dm_wr_en = 0;
        bus_if.dm_addr = 0; bus_if.dm_wdata = 0; bus_if.bus_rdata = 0; bus_if.bus_ack = 0;
        bus_if.err_clr = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 0;
        tick();
        tick();
        rst_n = 1;
    endtask

    // fetch access that never sees ack; optionally clears the error in the abort cycle
    task automatic timeout_run(input bit clr_same_cycle, input logic exp_err_before);
        tick();
        bus_if.if_req = 1; bus_if.if_addr = 32'h40; bus_if.bus_ack = 0;
        for (int k = 1; k <= MAX_WAIT; k++) begin
            tick();
            if (k == MAX_WAIT && clr_same_cycle) bus_if.err_clr = 1;
            @(negedge clk);
            chk("to_if_ready", 32'(bus_if.if_ready), 32'(k == MAX_WAIT));
            if (k == MAX_WAIT) begin
                chk("to_if_rdata", bus_if.if_rdata, 32'd0);
                chk("to_err_before", 32'(bus_if.bus_error), 32'(exp_err_before));
            end
        end
        tick();
        bus_if.if_req = 0; bus_if.err_clr = 0;
        @(negedge clk);
        chk("to_err_after", 32'(bus_if.bus_error), 32'd1);
        chk("to_bus_req_off", 32'(bus_if.bus_req), 32'd0);
    endtask

    initial begin
        int silent;
        clear_inputs();
        #12;
        chk("rst_bus_we", 32'(bus_if.bus_we), 32'd0);
        chk("rst_bus_addr", bus_if.bus_addr, 32'd0);
        chk("rst_bus_wdata", bus_if.bus_wdata, 32'd0);
        chk("rst_bus_error", 32'(bus_if.bus_error), 32'd0);
        chk("rst_readies", {30'd0, bus_if.if_ready, bus_if.dm_ready}, 32'd0);
        tick();
        rst_n = 1;

        // DM read at 0x100, two wait cycles then ack
        tick(); bus_if.dm_rd_en = 1; bus_if.dm_addr = 32'h100;
        @(negedge clk); chk("rd_c0_stall", 32'(bus_if.stall), 32'd1); chk("rd_c0_req", 32'(bus_if.bus_req), 32'd0);
        tick();
        @(negedge clk); chk("rd_c1_req", 32'(bus_if.bus_req), 32'd1); chk("rd_c1_addr", bus_if.bus_addr, 32'h100);
        tick();
        @(negedge clk); chk("rd_c2_stall", 32'(bus_if.stall), 32'd1); chk("rd_c2_ready", 32'(bus_if.dm_ready), 32'd0);
        tick(); bus_if.bus_ack = 1; bus_if.bus_rdata = 32'hDEADBEEF;
        @(negedge clk);
        chk("rd_c3_ready", 32'(bus_if.dm_ready), 32'd1);
        chk("rd_c3_rdata", bus_if.dm_rdata, 32'hDEADBEEF);
        chk("rd_c3_stall", 32'(bus_if.stall), 32'd0);
        chk("rd_c3_req", 32'(bus_if.bus_req), 32'd1);
        tick(); bus_if.bus_ack = 0; bus_if.dm_rd_en = 0;
        @(negedge clk); chk("rd_c4_req", 32'(bus_if.bus_req), 32'd0);

        // DM write, immediate ack
        tick(); bus_if.dm_wr_en = 1; bus_if.dm_addr = 32'h20; bus_if.dm_wdata = 32'h55AA;
        tick(); bus_if.bus_ack = 1;
        @(negedge clk);
        chk("wr_we", 32'(bus_if.bus_we), 32'd1);
        chk("wr_addr", bus_if.bus_addr, 32'h20);
        chk("wr_wdata", bus_if.bus_wdata, 32'h55AA);
        chk("wr_ready", 32'(bus_if.dm_ready), 32'd1);
        tick(); bus_if.bus_ack = 0; bus_if.dm_wr_en = 0;

        // starvation bound: both held, ack always high
        do_reset();
        begin
            bit got[$];
            bit exp_seq [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
            for (int c = 0; c < 20; c++) begin
                tick();
                bus_if.if_req = 1; bus_if.if_addr = 32'h1000; bus_if.dm_rd_en = 1;
                bus_if.dm_addr = 32'h2000; bus_if.bus_ack = 1;
                @(negedge clk);
                if (bus_if.if_ready || bus_if.dm_ready) got.push_back(bus_if.if_ready);
            end
            chk("starve_count", 32'(got.size()), 32'd10);
            for (int i = 0; i < 10 && i < got.size(); i++) chk("starve_order", 32'(got[i]), 32'(exp_seq[i]));
        end
        tick(); clear_inputs();

        // timeouts and the sticky error flag
        timeout_run(1'b0, 1'b0);
        tick(); bus_if.err_clr = 1;
        @(negedge clk); chk("clr_pending", 32'(bus_if.bus_error), 32'd1);
        tick(); bus_if.err_clr = 0;
        @(negedge clk); chk("clr_done", 32'(bus_if.bus_error), 32'd0);
        timeout_run(1'b1, 1'b0);
        tick(); bus_if.err_clr = 1;
        tick(); bus_if.err_clr = 0;

        // reset in the middle of a DM access
        tick(); bus_if.dm_rd_en = 1; bus_if.dm_addr = 32'h300;
        tick();
        tick();
        #2 rst_n = 0;
        #1 chk("arst_bus_req", 32'(bus_if.bus_req), 32'd0);
        tick(); rst_n = 1;
        @(negedge clk); chk("arst_rel_req", 32'(bus_if.bus_req), 32'd0);
        tick(); bus_if.bus_ack = 1;
        @(negedge clk);
        chk("arst_regrant", 32'(bus_if.bus_req), 32'd1);
        chk("arst_regrant_addr", bus_if.bus_addr, 32'h300);
        tick(); clear_inputs();

        // randomized traffic, checked entirely by the model
        silent = 0;
        for (int c = 0; c < 4000; c++) begin
            tick();
            if (bus_if.if_req && if_seen) bus_if.if_req = 0;
            if (!bus_if.if_req && ($urandom_range(2) == 0)) begin
                bus_if.if_req = 1; bus_if.if_addr = $urandom;
            end
            if ((bus_if.dm_rd_en || bus_if.dm_wr_en) && dm_seen) begin
                bus_if.dm_rd_en = 0; bus_if.dm_wr_en = 0;
            end
            if (!(bus_if.dm_rd_en || bus_if.dm_wr_en) && ($urandom_range(2) == 0)) begin
                case ($urandom_range(2))
                    0: bus_if.dm_rd_en = 1;
                    1: bus_if.dm_wr_en = 1;
                    default: begin bus_if.dm_rd_en = 1; bus_if.dm_wr_en = 1; end
                endcase
                bus_if.dm_addr = $urandom; bus_if.dm_wdata = $urandom;
            end
            if (silent > 0) begin
                bus_if.bus_ack = 0; silent--;
            end else if ($urandom_range(60) == 0) begin
                bus_if.bus_ack = 0; silent = 20;
            end else begin
                bus_if.bus_ack = ($urandom_range(2) == 0);
            end
            bus_if.bus_rdata = $urandom;
            bus_if.err_clr = ($urandom_range(15) == 0);
        end
        tick(); clear_inputs();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the core's single external memory port between instruction fetch (IF) and the execute unit's data accesses (DM).
- Latches the winning request, drives a req/ack bus with variable wait states, and returns data/ready to the requester.
- Generates the pipeline stall while a data access is outstanding.
- Bounds fetch starvation and aborts hung bus cycles with a sticky error flag.

Parameters:
- ADDR_WIDTH, 32, address width of all ports.
- DATA_WIDTH, 32, data width of all ports.
- MAX_WAIT, 16, bus cycles without ack before timeout abort (legal range 2 or more).
- STARVE_LIMIT, 4, consecutive DM wins over a waiting IF before IF is forced to win (legal range 1 or more).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- if_req  in  1  fetch request, held until if_ready
- if_addr  in  ADDR_WIDTH  fetch address
- if_rdata  out  DATA_WIDTH  fetch data, valid when if_ready
- if_ready  out  1  fetch complete, one-cycle pulse
- dm_rd_en  in  1  data read request, held until dm_ready
- dm_wr_en  in  1  data write request, held until dm_ready
- dm_addr  in  ADDR_WIDTH  data address
- dm_wdata  in  DATA_WIDTH  write data
- dm_rdata  out  DATA_WIDTH  read data, valid when dm_ready
- dm_ready  out  1  data access complete, one-cycle pulse
- stall  out  1  pipeline stall
- bus_req  out  1  bus cycle active
- bus_we  out  1  bus write
- bus_addr  out  ADDR_WIDTH  bus address
- bus_wdata  out  DATA_WIDTH  bus write data
- bus_rdata  in  DATA_WIDTH  bus read data, valid with bus_ack
- bus_ack  in  1  bus completion
- err_clr  in  1  clears bus_error
- bus_error  out  1  sticky timeout flag

Behaviour:
- FSM states: IDLE, IF_ACC, DM_ACC.
- Reset (async, any state): state=IDLE; bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0; wait_cnt=0, starve_cnt=0, bus_error=0. if_ready=dm_ready=0 and if_rdata=dm_rdata=0 while in IDLE.
- Arbitration, evaluated in IDLE only. dm_req = dm_rd_en | dm_wr_en.
  - dm_req only: go to DM_ACC.
  - if_req only: go to IF_ACC.
  - Both, starve_cnt < STARVE_LIMIT: DM wins and starve_cnt increments.
  - Both, starve_cnt == STARVE_LIMIT: IF wins.
  - Any IF grant clears starve_cnt. A DM grant with no if_req leaves starve_cnt unchanged.
- Grant latching: at the grant edge, bus_addr, bus_wdata and bus_we are registered and bus_req=1 from the next cycle.
  - bus_we = dm_wr_en for DM grants, 0 for IF grants.
  - If dm_rd_en and dm_wr_en are both high, the access is a write.
  - Request or address changes after the grant are ignored until completion.
- ACC states:
  - bus_ack=1: the granted requester's ready=1 combinationally in the same cycle, and its rdata = bus_rdata (write returns bus_rdata, don't care). Next state IDLE, bus_req=0, wait_cnt=0.
  - No ack: wait_cnt increments.
  - Timeout when wait_cnt == MAX_WAIT-1 with no ack: ready pulses with rdata=0, next state IDLE, bus_error set at that edge.
- Latency: request seen in IDLE at cycle 0, bus_req at cycle 1, ready in the ack cycle. Minimum 2 cycles; next grant is possible the cycle after ready.
- Non-granted requester: ready=0 and rdata=0.
- stall = dm_req & ~dm_ready (combinational). It is high throughout DM waiting, including while IF holds the bus.
- bus_error: sticky. err_clr clears it. If err_clr and a timeout occur in the same cycle, set wins.
- bus_ack outside an ACC state is ignored.

Test Plan:
- DM read at addr 0x100, ack after 2 wait cycles with bus_rdata=0xDEADBEEF -> bus_req high cycles 1-3, dm_ready pulses cycle 3 with dm_rdata=0xDEADBEEF, stall high cycles 0-2 and low at cycle 3.
- DM write 0x55AA to 0x20, immediate ack -> bus_we=1, bus_addr=0x20, bus_wdata=0x55AA, dm_ready at cycle 1, starve_cnt unchanged.
- if_req and dm_rd_en held continuously with 1-cycle acks, STARVE_LIMIT=4 -> grant order DM,DM,DM,DM,IF,DM,...; starve_cnt returns to 0 after the IF grant.
- No ack for 16 cycles on an IF access -> if_ready at the 16th bus cycle with if_rdata=0, bus_error=1 from the next cycle; err_clr pulse -> bus_error=0.
- rst_n asserted mid DM_ACC -> bus_req=0 immediately, state IDLE. After release, with dm_rd_en still held, a new grant occurs 1 cycle later.
- Simultaneous err_clr and timeout -> bus_error remains 1.
